seq_write_controller: RTL

SEQ_WRITE_CONTROLLER -- requirements
Module: seq_write_controller

---
 rtl/seq_write_controller.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/seq_write_controller.sv
// seq_write_controller
// Steps through a small pattern memory and replays each entry as a single
// register write on the signal generator bus, one step every tempo+1 clocks
// (at least two). A host port can inject direct writes at any time and wins
// the bus over a sequencer write in the same cycle.
//
// Build option: SEQ_LOOP_EN -- when defined, the loop input makes playback
// wrap from the last step back to step 0; otherwise loop is ignored and
// playback always ends with a done pulse.
//
// state  | meaning
// IDLE   | not playing; only host writes reach the bus
// ISSUE  | current step's write is due this cycle (held while the host owns the bus)
// WAIT   | step written; counting clocks until the next tick

module seq_write_controller #(
   parameter  int STEPS = 8,
   parameter  int DIV_W = 16,
   localparam int SW    = $clog2(STEPS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             loop,
   input  logic [DIV_W-1:0] tempo,
   input  logic [SW-1:0]    length,
   input  logic             prog_we,
   input  logic [SW-1:0]    prog_addr,
   input  logic [7:0]       prog_data,
   input  logic             host_req,
   input  logic [2:0]       host_addr,
   input  logic [4:0]       host_data,
   output logic             host_ack,
   output logic             write_strobe,
   output logic [2:0]       address,
   output logic [4:0]       data,
   output logic             busy,
   output logic [SW-1:0]    step,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [SW-1:0]    step_q, step_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic [2:0]       addr_q, addr_d;
   logic [4:0]       data_q, data_d;
   logic [7:0]       mem_q [STEPS];

   logic             host_go;
   logic             seq_fire;
   logic             loop_ok;
   logic [7:0]       entry;
   logic             is_rest;
   logic [DIV_W-1:0] tempo_m1;
   logic             tick;

`ifdef SEQ_LOOP_EN
   assign loop_ok = loop;
`else
   logic unused_loop;
   assign unused_loop = loop;
   assign loop_ok     = 1'b0;
`endif

   // The host grant is qualified by reset so nothing reaches the bus while rst is low.
   assign host_go  = host_req & rst;
   assign entry    = mem_q[step_q];
   assign is_rest  = (entry[7:5] == 3'b111);
   // A step lasts tempo+1 clocks: one ISSUE cycle plus tempo WAIT cycles (at least one).
   assign tempo_m1 = (tempo == '0) ? '0 : tempo - DIV_W'(1);
   assign tick     = (cnt_q >= tempo_m1);

   // Next-state, step advance and tick counter.
   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      seq_fire = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ISSUE;
               step_d  = '0;
            end
         end
         S_ISSUE: begin
            // A rest needs no bus, so it never waits behind the host.
            if (is_rest) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end else if (!host_go) begin
               seq_fire = 1'b1;
               state_d  = S_WAIT;
               cnt_d    = '0;
            end
         end
         S_WAIT: begin
            if (tick) begin
               if (step_q >= length) begin
                  if (loop_ok) begin
                     step_d  = '0;
                     state_d = S_ISSUE;
                  end else begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  step_d  = step_q + SW'(1);
                  state_d = S_ISSUE;
               end
            end else if (cnt_q != {DIV_W{1'b1}}) begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Abort overrides everything: no pending write, no done, step frozen.
      if (stop) begin
         state_d  = S_IDLE;
         step_d   = step_q;
         seq_fire = 1'b0;
         done_d   = 1'b0;
      end
   end

   // Bus mux: host first, then the sequencer, otherwise hold the last value.
   always_comb begin
      addr_d = addr_q;
      data_d = data_q;
      if (host_go) begin
         addr_d = host_addr;
         data_d = host_data;
      end else if (seq_fire) begin
         addr_d = entry[7:5];
         data_d = entry[4:0];
      end
   end

   assign host_ack     = host_go;
   assign write_strobe = host_go | seq_fire;
   assign address      = addr_d;
   assign data         = data_d;
   assign busy         = (state_q != S_IDLE);
   assign step         = step_q;
   assign done         = done_q;

   // Controller state, timing and bus hold registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         step_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // Pattern memory; the current step reads the value stored before this edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < STEPS; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else if (prog_we) begin
         mem_q[prog_addr] <= prog_data;
      end
   end

endmodule
